plab5_mcore_mem_net_tdm_sched: RTL and testbench
================================================

// Module: plab5_mcore_mem_net_tdm_sched
// PURPOSE
//  Temporal-partitioning scheduler in front of the two request injection ports of the
//  separated memory request/response network (proc ports p0/p1).
//  - Secure mode: alternates fixed-length epochs between security domains 0 and 1.
//    Only requests whose domain matches the current epoch are injected.
//  - A fixed dead time between epochs lets in-flight traffic clear.
//  - Tracks outstanding requests per port and enforces a credit limit.
//  - Insecure mode: epochs are ignored; only the credit limit applies.
// PARAMETERS
//  p_epoch_len   16  cycles per active epoch (>=1)
//  p_dead_len    8   cycles of dead time between epochs (>=1)
//  p_max_outst   4   max outstanding requests per port (>=1, <=255)
//  c_cnt_nbits   $clog2(max(p_epoch_len,p_dead_len)+1)  schedule counter width
//  c_out_nbits   $clog2(p_max_outst+1)                  outstanding counter width
// PORTS
//  clk             in   1  clock; all state on posedge
//  reset           in   1  asynchronous, active-low reset
//  mode            in   1  1 = secure (TDM gating on), 0 = insecure (TDM bypassed)
//  req_in_val_pN   in   1  requester valid, N = 0,1
//  req_in_domain_pN in  1  requester security domain
//  req_in_rdy_pN   out  1  ready back to requester
//  req_out_val_pN  out  1  valid to network injection port
//  req_out_rdy_pN  in   1  ready from network injection port
//  resp_val_pN     in   1  response valid at port N's response output
//  resp_rdy_pN     in   1  response ready at port N's response output
//  cur_domain      out  1  domain owning the current/last epoch
//  dead            out  1  1 while in dead time
//  outst_pN        out  c_out_nbits  outstanding request count, port N
//  err             out  1  sticky: response seen with zero outstanding
// BEHAVIOUR
//  - States: EPOCH, DEAD. Down-counter cnt.
//  - Reset (async, reset==0): state=EPOCH, cnt=p_epoch_len-1, cur_domain=0, outst_pN=0, err=0.
//    Outputs: dead=0; req_out_val_pN=0 and req_in_rdy_pN=0 while reset is asserted.
//    Reset mid-epoch or mid-transaction discards all state; no requests are lost beyond the handshake.
//  - Transitions:
//    EPOCH, cnt==0: ->DEAD, cnt=p_dead_len-1.
//    DEAD, cnt==0: ->EPOCH, cnt=p_epoch_len-1, cur_domain flips.
//    Otherwise cnt decrements by 1.
//    Schedule runs identically in both modes, so the epoch phase is independent of traffic and of mode.
//  - allow_pN = credit_pN & (mode==0 | (state==EPOCH & req_in_domain_pN==cur_domain)).
//    credit_pN = (outst_pN < p_max_outst).
//  - Pass-through is combinational, 0 latency:
//    req_out_val_pN = req_in_val_pN & allow_pN
//    req_in_rdy_pN  = req_out_rdy_pN & allow_pN
//  - Valid/ready rules: no dependence of val on rdy. A blocked request keeps its val
//    upstream; fire happens only on val&rdy at the network side.
//  - Outstanding counters:
//    - req fire, no resp fire: +1.
//    - resp fire (resp_val_pN&resp_rdy_pN), no req fire: -1.
//    - Both in the same cycle: unchanged.
//    - Resp fire with outst_pN==0: counter holds 0 and err<=1 (sticky until reset).
//    - Counter never exceeds p_max_outst (guaranteed by credit gating).
//  - Last EPOCH cycle (cnt==0) still grants; first DEAD cycle grants nothing in secure mode.
//  - Mode toggles take effect combinationally the same cycle. Counters are unaffected.
//  - p_epoch_len==1 / p_dead_len==1: each state lasts exactly one cycle.
// CONFIGURATION
//  PLAB5_MCORE_TDM_STALL_CNT_EN defined:
//    - Adds outputs stall_cnt_d0, stall_cnt_d1 (32 bits each), reset to 0.
//    - Each increments by 1 per port per cycle in which req_in_val_pN=1, the domain
//      matches, and allow_pN=0 (0, 1 or 2 per cycle).
//    - Saturates at 2^32-1.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset, mode=1, p_epoch_len=16, p_dead_len=8, p0 domain0 val held, out_rdy=1
//    -> 16 fires in cycles 0-15, none in 16-23, none in 24-39, fires resume at 48.
//  2 mode=1, p1 domain1 val held from cycle 0 -> first fire at cycle 24, cur_domain=1,
//    dead=1 exactly in cycles 16-23.
//  3 mode=0, p0 continuous val, no responses, p_max_outst=4
//    -> exactly 4 fires, outst_p0=4, in_rdy=0 after. One resp fire re-enables 1 more request.
//  4 Req fire and resp fire same cycle at outst_p1=2 -> outst_p1 stays 2.
//    Resp fire at outst=0 -> outst=0, err=1 persisting.
//  5 Reset asserted at cycle 10 of an epoch with outst_p0=3
//    -> all outputs at reset values immediately; after release, cnt restarts at 15 with cur_domain=0.
//  6 With the macro: mode=1, p0 domain1 val held 16 cycles from reset, credit available
//    -> stall_cnt_d1=16, stall_cnt_d0=0.

Source files
------------

// File: rtl/plab5_mcore_mem_net_tdm_sched_if.sv
// Request/response handshake bundle for the TDM injection scheduler.
// Optional stall counters appear only when PLAB5_MCORE_TDM_STALL_CNT_EN is defined.
interface plab5_mcore_mem_net_tdm_sched_if #(
  parameter int unsigned p_max_outst = 4
);
  localparam int unsigned c_out_nbits = $clog2(p_max_outst + 1);

  logic                   mode;
  logic                   req_in_val_p0;
  logic                   req_in_domain_p0;
  logic                   req_in_rdy_p0;
  logic                   req_out_val_p0;
  logic                   req_out_rdy_p0;
  logic                   resp_val_p0;
  logic                   resp_rdy_p0;
  logic                   req_in_val_p1;
  logic                   req_in_domain_p1;
  logic                   req_in_rdy_p1;
  logic                   req_out_val_p1;
  logic                   req_out_rdy_p1;
  logic                   resp_val_p1;
  logic                   resp_rdy_p1;
  logic                   cur_domain;
  logic                   dead;
  logic [c_out_nbits-1:0] outst_p0;
  logic [c_out_nbits-1:0] outst_p1;
  logic                   err;
`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
  logic [31:0]            stall_cnt_d0;
  logic [31:0]            stall_cnt_d1;
`endif

  // Requester / network / response side of the scheduler
  modport master (
    output mode,
    output req_in_val_p0, req_in_domain_p0, req_out_rdy_p0, resp_val_p0, resp_rdy_p0,
    output req_in_val_p1, req_in_domain_p1, req_out_rdy_p1, resp_val_p1, resp_rdy_p1,
    input  req_in_rdy_p0, req_out_val_p0, req_in_rdy_p1, req_out_val_p1,
    input  cur_domain, dead, outst_p0, outst_p1, err
`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
    , input stall_cnt_d0, stall_cnt_d1
`endif
  );

  // Scheduler side
  modport slave (
    input  mode,
    input  req_in_val_p0, req_in_domain_p0, req_out_rdy_p0, resp_val_p0, resp_rdy_p0,
    input  req_in_val_p1, req_in_domain_p1, req_out_rdy_p1, resp_val_p1, resp_rdy_p1,
    output req_in_rdy_p0, req_out_val_p0, req_in_rdy_p1, req_out_val_p1,
    output cur_domain, dead, outst_p0, outst_p1, err
`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
    , output stall_cnt_d0, stall_cnt_d1
`endif
  );
endinterface

// File: rtl/plab5_mcore_mem_net_tdm_sched.sv
// Temporal-partitioning scheduler for the two memory request injection ports.
// Alternates epochs between security domains 0/1 separated by dead time, gates
// injection by domain (secure mode) and by per-port outstanding-request credit.
// Optional: PLAB5_MCORE_TDM_STALL_CNT_EN adds per-domain saturating stall counters.
module plab5_mcore_mem_net_tdm_sched #(
  parameter int unsigned p_epoch_len = 16,
  parameter int unsigned p_dead_len  = 8,
  parameter int unsigned p_max_outst = 4
) (
  input  logic clk,
  input  logic reset,
  plab5_mcore_mem_net_tdm_sched_if.slave bus
);

  localparam int unsigned c_cnt_max   = (p_epoch_len > p_dead_len) ? p_epoch_len : p_dead_len;
  localparam int unsigned c_cnt_nbits = $clog2(c_cnt_max + 1);
  localparam int unsigned c_out_nbits = $clog2(p_max_outst + 1);

  localparam logic [c_cnt_nbits-1:0] c_epoch_last = c_cnt_nbits'(p_epoch_len - 1);
  localparam logic [c_cnt_nbits-1:0] c_dead_last  = c_cnt_nbits'(p_dead_len - 1);
  localparam logic [c_out_nbits-1:0] c_outst_max  = c_out_nbits'(p_max_outst);

  typedef enum logic {ST_EPOCH, ST_DEAD} state_t;

  state_t                 r_state;
  logic [c_cnt_nbits-1:0] r_cnt;
  logic                   r_cur_domain;
  logic [c_out_nbits-1:0] r_outst [2];
  logic                   r_err;

  logic [1:0] w_in_val;
  logic [1:0] w_dom;
  logic [1:0] w_out_rdy;
  logic [1:0] w_resp_fire;
  logic [1:0] w_allow;
  logic [1:0] w_req_fire;

  assign w_in_val    = {bus.req_in_val_p1,    bus.req_in_val_p0};
  assign w_dom       = {bus.req_in_domain_p1, bus.req_in_domain_p0};
  assign w_out_rdy   = {bus.req_out_rdy_p1,   bus.req_out_rdy_p0};
  assign w_resp_fire = {bus.resp_val_p1 & bus.resp_rdy_p1,
                        bus.resp_val_p0 & bus.resp_rdy_p0};

  // Per-port grant: credit always required; domain/epoch match only in secure mode.
  // Reset forces both handshakes low so nothing can fire while state is discarded.
  always_comb begin
    w_allow    = '0;
    w_req_fire = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      w_allow[n] = reset & (r_outst[n] < c_outst_max) &
                   (~bus.mode | ((r_state == ST_EPOCH) & (w_dom[n] == r_cur_domain)));
      w_req_fire[n] = w_in_val[n] & w_allow[n] & w_out_rdy[n];
    end
  end

  assign bus.req_out_val_p0 = w_in_val[0] & w_allow[0];
  assign bus.req_out_val_p1 = w_in_val[1] & w_allow[1];
  assign bus.req_in_rdy_p0  = w_out_rdy[0] & w_allow[0];
  assign bus.req_in_rdy_p1  = w_out_rdy[1] & w_allow[1];
  assign bus.cur_domain     = r_cur_domain;
  assign bus.dead           = (r_state == ST_DEAD);
  assign bus.outst_p0       = r_outst[0];
  assign bus.outst_p1       = r_outst[1];
  assign bus.err            = r_err;

  // Epoch/dead schedule: free-running regardless of mode and traffic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_EPOCH;
      r_cnt        <= c_epoch_last;
      r_cur_domain <= 1'b0;
    end else if (r_cnt == '0) begin
      if (r_state == ST_EPOCH) begin
        r_state <= ST_DEAD;
        r_cnt   <= c_dead_last;
      end else begin
        r_state      <= ST_EPOCH;
        r_cnt        <= c_epoch_last;
        r_cur_domain <= ~r_cur_domain;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Outstanding-request tracking and sticky underflow error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outst[0] <= '0;
      r_outst[1] <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        if (w_req_fire[n] & ~w_resp_fire[n]) begin
          r_outst[n] <= r_outst[n] + 1'b1;
        end else if (~w_req_fire[n] & w_resp_fire[n] & (r_outst[n] != '0)) begin
          r_outst[n] <= r_outst[n] - 1'b1;
        end
        if (w_resp_fire[n] & (r_outst[n] == '0)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
  logic [31:0] r_stall_d0;
  logic [31:0] r_stall_d1;
  logic [1:0]  w_stall;
  logic [1:0]  w_inc_d0;
  logic [1:0]  w_inc_d1;
  logic [32:0] w_sum_d0;
  logic [32:0] w_sum_d1;

  // Stalls are charged to the requesting domain; up to two per cycle per counter
  always_comb begin
    w_stall  = w_in_val & ~w_allow;
    w_inc_d0 = {1'b0, w_stall[0] & ~w_dom[0]} + {1'b0, w_stall[1] & ~w_dom[1]};
    w_inc_d1 = {1'b0, w_stall[0] &  w_dom[0]} + {1'b0, w_stall[1] &  w_dom[1]};
    w_sum_d0 = {1'b0, r_stall_d0} + {31'b0, w_inc_d0};
    w_sum_d1 = {1'b0, r_stall_d1} + {31'b0, w_inc_d1};
  end

  // Saturating stall counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_d0 <= '0;
      r_stall_d1 <= '0;
    end else begin
      r_stall_d0 <= w_sum_d0[32] ? '1 : w_sum_d0[31:0];
      r_stall_d1 <= w_sum_d1[32] ? '1 : w_sum_d1[31:0];
    end
  end

  assign bus.stall_cnt_d0 = r_stall_d0;
  assign bus.stall_cnt_d1 = r_stall_d1;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_net_tdm_sched.sv
// Self-checking bench for plab5_mcore_mem_net_tdm_sched (default 16/8/4 instance
// plus a 1/1 schedule instance). Build with PLAB5_MCORE_TDM_STALL_CNT_EN to cover stall counters.
module tb_plab5_mcore_mem_net_tdm_sched;

  localparam int E = 16;
  localparam int D = 8;
  localparam int M = 4;

  logic clk;
  logic rst_n;

  plab5_mcore_mem_net_tdm_sched_if #(.p_max_outst(M)) u_if ();
  plab5_mcore_mem_net_tdm_sched_if #(.p_max_outst(M)) u_if2 ();

  plab5_mcore_mem_net_tdm_sched #(
    .p_epoch_len(E), .p_dead_len(D), .p_max_outst(M)
  ) u_dut (.clk(clk), .reset(rst_n), .bus(u_if));

  plab5_mcore_mem_net_tdm_sched #(
    .p_epoch_len(1), .p_dead_len(1), .p_max_outst(M)
  ) u_dut2 (.clk(clk), .reset(rst_n), .bus(u_if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  int     t        = 0;
  int     m_outst [2];
  bit     m_err;
  longint m_stall [2];
  bit     dut_fire [2];
  bit     dut_dead;
  bit     dut_dom;

  typedef struct {
    bit mode;
    bit v0, d0, r0;
    bit v1, d1, r1;
    bit ov0, ir0, ov1, ir1;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", name, t, act, exp);
    end
  endtask

  task automatic clr_inputs();
    u_if.mode = 1'b0;
    u_if.req_in_val_p0 = 0; u_if.req_in_domain_p0 = 0; u_if.req_out_rdy_p0 = 0;
    u_if.resp_val_p0 = 0;   u_if.resp_rdy_p0 = 0;
    u_if.req_in_val_p1 = 0; u_if.req_in_domain_p1 = 0; u_if.req_out_rdy_p1 = 0;
    u_if.resp_val_p1 = 0;   u_if.resp_rdy_p1 = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with reset released (cycle 0)
  task automatic do_reset();
    rst_n = 1'b0;
    m_outst[0] = 0; m_outst[1] = 0; m_err = 0;
    m_stall[0] = 0; m_stall[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
  endtask

  // One cycle: compare against the schedule/credit model, then advance
  task automatic cycle_chk();
    bit dead_m, dom_m;
    bit allow [2];
    bit val [2], dm [2], ordy [2], rf [2], qf [2];
    val[0] = u_if.req_in_val_p0; dm[0] = u_if.req_in_domain_p0; ordy[0] = u_if.req_out_rdy_p0;
    val[1] = u_if.req_in_val_p1; dm[1] = u_if.req_in_domain_p1; ordy[1] = u_if.req_out_rdy_p1;
    rf[0] = u_if.resp_val_p0 & u_if.resp_rdy_p0;
    rf[1] = u_if.resp_val_p1 & u_if.resp_rdy_p1;
    #3;
    dead_m = (t % (E + D)) >= E;
    dom_m  = ((t / (E + D)) % 2) == 1;
    for (int n = 0; n < 2; n++)
      allow[n] = (m_outst[n] < M) && (!u_if.mode || (!dead_m && dm[n] == dom_m));
    chk("out_val_p0", u_if.req_out_val_p0, val[0] && allow[0]);
    chk("in_rdy_p0",  u_if.req_in_rdy_p0,  ordy[0] && allow[0]);
    chk("out_val_p1", u_if.req_out_val_p1, val[1] && allow[1]);
    chk("in_rdy_p1",  u_if.req_in_rdy_p1,  ordy[1] && allow[1]);
    chk("dead",       u_if.dead,       dead_m);
    chk("cur_domain", u_if.cur_domain, dom_m);
    chk("outst_p0",   u_if.outst_p0,   m_outst[0]);
    chk("outst_p1",   u_if.outst_p1,   m_outst[1]);
    chk("err",        u_if.err,        m_err);
    chk("dead_e1",    u_if2.dead,       t % 2);
    chk("dom_e1",     u_if2.cur_domain, (t / 2) % 2);
`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
    chk("stall_d0", u_if.stall_cnt_d0, m_stall[0]);
    chk("stall_d1", u_if.stall_cnt_d1, m_stall[1]);
`endif
    dut_fire[0] = u_if.req_out_val_p0 & u_if.req_out_rdy_p0;
    dut_fire[1] = u_if.req_out_val_p1 & u_if.req_out_rdy_p1;
    dut_dead = u_if.dead;
    dut_dom  = u_if.cur_domain;
    for (int n = 0; n < 2; n++) begin
      qf[n] = val[n] && allow[n] && ordy[n];
      if (rf[n] && m_outst[n] == 0) m_err = 1;
      if (qf[n] && !rf[n]) m_outst[n]++;
      else if (!qf[n] && rf[n] && m_outst[n] > 0) m_outst[n]--;
      if (val[n] && !allow[n] && m_stall[dm[n]] < 64'hFFFF_FFFF) m_stall[dm[n]]++;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, dcnt, dfirst, dlast;
    //         mode v0 d0 r0 v1 d1 r1  ov0 ir0 ov1 ir1
    vecs[0] = '{1, 1, 0, 1, 1, 1, 1,  1, 1, 0, 0};
    vecs[1] = '{1, 1, 1, 1, 1, 0, 1,  0, 0, 1, 1};
    vecs[2] = '{0, 1, 1, 1, 1, 1, 0,  1, 1, 1, 0};
    vecs[3] = '{1, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0};
    vecs[4] = '{0, 1, 0, 0, 0, 1, 1,  1, 0, 0, 1};
    vecs[5] = '{1, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0};

    rst_n = 1'b0;
    clr_inputs();
    u_if2.mode = 0;
    u_if2.req_in_val_p0 = 0; u_if2.req_in_domain_p0 = 0; u_if2.req_out_rdy_p0 = 0;
    u_if2.resp_val_p0 = 0;   u_if2.resp_rdy_p0 = 0;
    u_if2.req_in_val_p1 = 0; u_if2.req_in_domain_p1 = 0; u_if2.req_out_rdy_p1 = 0;
    u_if2.resp_val_p1 = 0;   u_if2.resp_rdy_p1 = 0;
    @(posedge clk);
    #1;

    // Reset state with requests presented
    u_if.req_in_val_p0 = 1; u_if.req_out_rdy_p0 = 1;
    u_if.req_in_val_p1 = 1; u_if.req_out_rdy_p1 = 1;
    #2;
    chk("rst_out_val_p0", u_if.req_out_val_p0, 0);
    chk("rst_in_rdy_p1",  u_if.req_in_rdy_p1, 0);
    chk("rst_dead",       u_if.dead, 0);
    chk("rst_dom",        u_if.cur_domain, 0);
    chk("rst_outst_p0",   u_if.outst_p0, 0);
    chk("rst_err",        u_if.err, 0);
    @(posedge clk);
    #1;

    // Combinational gating table at cycle 0 (epoch of domain 0, full credit)
    for (int i = 0; i < 6; i++) begin
      do_reset();
      clr_inputs();
      u_if.mode = vecs[i].mode;
      u_if.req_in_val_p0 = vecs[i].v0; u_if.req_in_domain_p0 = vecs[i].d0;
      u_if.req_out_rdy_p0 = vecs[i].r0;
      u_if.req_in_val_p1 = vecs[i].v1; u_if.req_in_domain_p1 = vecs[i].d1;
      u_if.req_out_rdy_p1 = vecs[i].r1;
      #2;
      chk("tbl_out_val_p0", u_if.req_out_val_p0, vecs[i].ov0);
      chk("tbl_in_rdy_p0",  u_if.req_in_rdy_p0,  vecs[i].ir0);
      chk("tbl_out_val_p1", u_if.req_out_val_p1, vecs[i].ov1);
      chk("tbl_in_rdy_p1",  u_if.req_in_rdy_p1,  vecs[i].ir1);
    end

    // Secure mode, p0 domain 0 held: epoch windows
    do_reset();
    clr_inputs();
    u_if.mode = 1; u_if.req_in_val_p0 = 1; u_if.req_out_rdy_p0 = 1; u_if.resp_rdy_p0 = 1;
    cnt = 0; dcnt = 0; first = -1;
    for (int c = 0; c < 56; c++) begin
      u_if.resp_val_p0 = (m_outst[0] > 0);
      cycle_chk();
      if (c < 16 && dut_fire[0]) cnt++;
      if (c >= 16 && c < 48 && dut_fire[0]) dcnt++;
      if (c == 48) first = dut_fire[0];
    end
    chk("t1_fires_0_15", cnt, 16);
    chk("t1_fires_16_47", dcnt, 0);
    chk("t1_fire_48", first, 1);

    // Secure mode, p1 domain 1 held: first grant after the dead time
    do_reset();
    clr_inputs();
    u_if.mode = 1; u_if.req_in_val_p1 = 1; u_if.req_in_domain_p1 = 1;
    u_if.req_out_rdy_p1 = 1; u_if.resp_rdy_p1 = 1;
    first = -1; dcnt = 0; dfirst = -1; dlast = -1; cnt = -1;
    for (int c = 0; c < 40; c++) begin
      u_if.resp_val_p1 = (m_outst[1] > 0);
      cycle_chk();
      if (dut_fire[1] && first < 0) begin first = c; cnt = dut_dom; end
      if (dut_dead) begin dcnt++; dlast = c; if (dfirst < 0) dfirst = c; end
    end
    chk("t2_first_fire", first, 24);
    chk("t2_dom_at_fire", cnt, 1);
    chk("t2_dead_cycles", dcnt, 8);
    chk("t2_dead_first", dfirst, 16);
    chk("t2_dead_last", dlast, 23);

    // Insecure mode credit limit
    do_reset();
    clr_inputs();
    u_if.req_in_val_p0 = 1; u_if.req_out_rdy_p0 = 1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin cycle_chk(); if (dut_fire[0]) cnt++; end
    chk("t3_fires", cnt, 4);
    chk("t3_outst", u_if.outst_p0, 4);
    chk("t3_in_rdy", u_if.req_in_rdy_p0, 0);
    u_if.resp_val_p0 = 1; u_if.resp_rdy_p0 = 1;
    cycle_chk();
    u_if.resp_val_p0 = 0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin cycle_chk(); if (dut_fire[0]) cnt++; end
    chk("t3_refire", cnt, 1);
    chk("t3_outst_after", u_if.outst_p0, 4);

    // Simultaneous req/resp fire, then underflow error
    do_reset();
    clr_inputs();
    u_if.req_in_val_p1 = 1; u_if.req_out_rdy_p1 = 1; u_if.resp_rdy_p1 = 1;
    repeat (2) cycle_chk();
    chk("t4_outst_2", u_if.outst_p1, 2);
    u_if.resp_val_p1 = 1;
    cycle_chk();
    chk("t4_outst_same", u_if.outst_p1, 2);
    u_if.req_in_val_p1 = 0;
    repeat (2) cycle_chk();
    chk("t4_outst_0", u_if.outst_p1, 0);
    chk("t4_err_pre", u_if.err, 0);
    cycle_chk();
    u_if.resp_val_p1 = 0;
    chk("t4_outst_hold0", u_if.outst_p1, 0);
    chk("t4_err_set", u_if.err, 1);
    repeat (3) cycle_chk();
    chk("t4_err_sticky", u_if.err, 1);

    // Asynchronous reset mid-epoch with outstanding requests
    do_reset();
    clr_inputs();
    u_if.mode = 1; u_if.req_in_val_p0 = 1; u_if.req_out_rdy_p0 = 1;
    repeat (3) cycle_chk();
    u_if.req_in_val_p0 = 0;
    repeat (7) cycle_chk();
    chk("t5_outst_3", u_if.outst_p0, 3);
    u_if.req_in_val_p0 = 1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_val", u_if.req_out_val_p0, 0);
    chk("t5_in_rdy", u_if.req_in_rdy_p0, 0);
    chk("t5_outst", u_if.outst_p0, 0);
    chk("t5_dead", u_if.dead, 0);
    chk("t5_dom", u_if.cur_domain, 0);
    chk("t5_err", u_if.err, 0);
    @(posedge clk);
    #1;
    do_reset();
    u_if.req_in_val_p0 = 0;
    dfirst = -1;
    for (int c = 0; c < 20; c++) begin
      cycle_chk();
      if (dut_dead && dfirst < 0) dfirst = c;
    end
    chk("t5_restart_dead_at", dfirst, 16);

`ifdef PLAB5_MCORE_TDM_STALL_CNT_EN
    // Domain-1 request held through a domain-0 epoch
    do_reset();
    clr_inputs();
    u_if.mode = 1; u_if.req_in_val_p0 = 1; u_if.req_in_domain_p0 = 1; u_if.req_out_rdy_p0 = 1;
    repeat (16) cycle_chk();
    chk("t6_stall_d1", u_if.stall_cnt_d1, 16);
    chk("t6_stall_d0", u_if.stall_cnt_d0, 0);
`endif

    // Randomized traffic against the model
    for (int s = 0; s < 3; s++) begin
      do_reset();
      clr_inputs();
      u_if.mode = $urandom_range(1);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(19) == 0) u_if.mode = ~u_if.mode;
        u_if.req_in_val_p0 = ($urandom_range(9) < 7);
        u_if.req_in_val_p1 = ($urandom_range(9) < 7);
        if ($urandom_range(7) == 0) u_if.req_in_domain_p0 = ~u_if.req_in_domain_p0;
        if ($urandom_range(7) == 0) u_if.req_in_domain_p1 = ~u_if.req_in_domain_p1;
        u_if.req_out_rdy_p0 = ($urandom_range(9) < 8);
        u_if.req_out_rdy_p1 = ($urandom_range(9) < 8);
        u_if.resp_val_p0 = (m_outst[0] > 0) ? ($urandom_range(9) < 4) : ($urandom_range(63) == 0);
        u_if.resp_val_p1 = (m_outst[1] > 0) ? ($urandom_range(9) < 4) : ($urandom_range(63) == 0);
        u_if.resp_rdy_p0 = ($urandom_range(9) < 8);
        u_if.resp_rdy_p1 = ($urandom_range(9) < 8);
        cycle_chk();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
